// File: rtl/wb_timeout_reg.sv
// wb_timeout_reg: registered single-outstanding Wishbone pipeline stage with
// a bus watchdog. The master request is registered toward the slave. The
// slave response is registered back to the master as a one-cycle flag. An
// access the slave leaves unanswered for TIMEOUT cycles is ended with an error.
// Optional feature macro: WB_TIMEOUT_CNT_EN adds timeout_count_o. This output
// is a saturating count of errors raised by the watchdog.
module wb_timeout_reg #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int SELECT_WIDTH = DATA_WIDTH / 8,
    parameter int TIMEOUT      = 256,
    parameter int CNT_WIDTH    = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [DATA_WIDTH-1:0]   wbm_dat_o,
    input  logic                    wbm_we_i,
    input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
    input  logic                    wbm_stb_i,
    output logic                    wbm_ack_o,
    output logic                    wbm_err_o,
    output logic                    wbm_rty_o,
    input  logic                    wbm_cyc_i,
    output logic [ADDR_WIDTH-1:0]   wbs_adr_o,
    input  logic [DATA_WIDTH-1:0]   wbs_dat_i,
    output logic [DATA_WIDTH-1:0]   wbs_dat_o,
    output logic                    wbs_we_o,
    output logic [SELECT_WIDTH-1:0] wbs_sel_o,
    output logic                    wbs_stb_o,
    input  logic                    wbs_ack_i,
    input  logic                    wbs_err_i,
    input  logic                    wbs_rty_i,
    output logic                    wbs_cyc_o
`ifdef WB_TIMEOUT_CNT_EN
    ,
    output logic [15:0]             timeout_count_o
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Last counter value before the watchdog fires. The counter is only
    // compared against this value, so the counter never needs to wrap.
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    state_t                  state_reg, state_next;
    logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;
    logic [ADDR_WIDTH-1:0]   adr_reg, adr_next;
    logic [DATA_WIDTH-1:0]   wdat_reg, wdat_next;
    logic [DATA_WIDTH-1:0]   rdat_reg, rdat_next;
    logic                    we_reg, we_next;
    logic [SELECT_WIDTH-1:0] sel_reg, sel_next;
    logic                    stb_reg, stb_next;
    logic                    ack_reg, ack_next;
    logic                    err_reg, err_next;
    logic                    rty_reg, rty_next;
    logic                    slave_resp;
    logic                    wdog_fire;

    assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;
    assign wdog_fire  = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

    // State and every output register; a reset drops an access in flight at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            adr_reg   <= '0;
            wdat_reg  <= '0;
            rdat_reg  <= '0;
            we_reg    <= 1'b0;
            sel_reg   <= '0;
            stb_reg   <= 1'b0;
            ack_reg   <= 1'b0;
            err_reg   <= 1'b0;
            rty_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            adr_reg   <= adr_next;
            wdat_reg  <= wdat_next;
            rdat_reg  <= rdat_next;
            we_reg    <= we_next;
            sel_reg   <= sel_next;
            stb_reg   <= stb_next;
            ack_reg   <= ack_next;
            err_reg   <= err_next;
            rty_reg   <= rty_next;
        end
    end

    // Next-state logic; response flags default low so each lasts one cycle
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        adr_next   = adr_reg;
        wdat_next  = wdat_reg;
        rdat_next  = rdat_reg;
        we_next    = we_reg;
        sel_next   = sel_reg;
        stb_next   = stb_reg;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        rty_next   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (wbm_cyc_i && wbm_stb_i) begin
                    adr_next   = wbm_adr_i;
                    wdat_next  = wbm_dat_i;
                    we_next    = wbm_we_i;
                    sel_next   = wbm_sel_i;
                    stb_next   = 1'b1;
                    cnt_next   = '0;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!wbm_cyc_i) begin
                    // The master gave up: release the slave quietly
                    stb_next   = 1'b0;
                    state_next = ST_IDLE;
                end else if (slave_resp) begin
                    // A slave answer in the watchdog's final cycle still wins
                    rdat_next  = wbs_dat_i;
                    stb_next   = 1'b0;
                    ack_next   = wbs_ack_i;
                    err_next   = !wbs_ack_i && wbs_err_i;
                    rty_next   = !wbs_ack_i && !wbs_err_i && wbs_rty_i;
                    state_next = ST_RESP;
                end else if (wdog_fire) begin
                    stb_next   = 1'b0;
                    err_next   = 1'b1;
                    state_next = ST_RESP;
                end else begin
                    cnt_next = cnt_reg + CNT_WIDTH'(1);
                end
            end
            ST_RESP: begin
                // A strobe held through the response is not sampled here,
                // so one request can never start two accesses
                state_next = ST_IDLE;
            end
            default: begin
                stb_next   = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef WB_TIMEOUT_CNT_EN
    logic [15:0] tcount_reg;
    logic        tcount_inc;

    // The watchdog fires only if the master still holds cyc and no slave answer came
    assign tcount_inc = (state_reg == ST_BUSY) && wbm_cyc_i && !slave_resp && wdog_fire;

    // Saturating count of accesses ended by the watchdog
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcount_reg <= 16'd0;
        end else if (tcount_inc && (tcount_reg != 16'hFFFF)) begin
            tcount_reg <= tcount_reg + 16'd1;
        end
    end

    assign timeout_count_o = tcount_reg;
`endif

    assign wbm_dat_o = rdat_reg;
    assign wbm_ack_o = ack_reg;
    assign wbm_err_o = err_reg;
    assign wbm_rty_o = rty_reg;
    assign wbs_adr_o = adr_reg;
    assign wbs_dat_o = wdat_reg;
    assign wbs_we_o  = we_reg;
    assign wbs_sel_o = sel_reg;
    assign wbs_stb_o = stb_reg;
    assign wbs_cyc_o = stb_reg;

endmodule

// File: tb/tb_wb_timeout_reg.sv
// Directed testbench for wb_timeout_reg (TIMEOUT = 8). A negedge monitor
// counts strobe and response pulses. Each scenario compares deltas of these
// counts, and the outputs it sees, against hand-derived values.
`timescale 1ns/1ps
module tb_wb_timeout_reg;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] wbm_adr_i = '0;
    logic [31:0] wbm_dat_i = '0;
    logic [31:0] wbm_dat_o;
    logic        wbm_we_i = 1'b0;
    logic [3:0]  wbm_sel_i = '0;
    logic        wbm_stb_i = 1'b0;
    logic        wbm_ack_o, wbm_err_o, wbm_rty_o;
    logic        wbm_cyc_i = 1'b0;
    logic [31:0] wbs_adr_o;
    logic [31:0] wbs_dat_i = '0;
    logic [31:0] wbs_dat_o;
    logic        wbs_we_o;
    logic [3:0]  wbs_sel_o;
    logic        wbs_stb_o;
    logic        wbs_ack_i = 1'b0, wbs_err_i = 1'b0, wbs_rty_i = 1'b0;
    logic        wbs_cyc_o;
`ifdef WB_TIMEOUT_CNT_EN
    logic [15:0] timeout_count_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    wb_timeout_reg #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4),
        .TIMEOUT(8), .CNT_WIDTH(9)
    ) dut (
        .clk(clk), .rst(rst),
        .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_dat_o(wbm_dat_o),
        .wbm_we_i(wbm_we_i), .wbm_sel_i(wbm_sel_i), .wbm_stb_i(wbm_stb_i),
        .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o), .wbm_rty_o(wbm_rty_o),
        .wbm_cyc_i(wbm_cyc_i),
        .wbs_adr_o(wbs_adr_o), .wbs_dat_i(wbs_dat_i), .wbs_dat_o(wbs_dat_o),
        .wbs_we_o(wbs_we_o), .wbs_sel_o(wbs_sel_o), .wbs_stb_o(wbs_stb_o),
        .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i), .wbs_rty_i(wbs_rty_i),
        .wbs_cyc_o(wbs_cyc_o)
`ifdef WB_TIMEOUT_CNT_EN
        , .timeout_count_o(timeout_count_o)
`endif
    );

    always #5 clk = ~clk;

    // Pulse monitor: rising edges and high cycles of the strobe and the response flags
    logic stb_q = 1'b0, ack_q = 1'b0, err_q = 1'b0, rty_q = 1'b0;
    int stb_rise = 0, stb_cyc = 0, ack_rise = 0, ack_cyc = 0;
    int err_rise = 0, err_cyc = 0, rty_rise = 0, rty_cyc = 0;

    always @(negedge clk) begin
        if (wbs_stb_o) stb_cyc++;
        if (wbs_stb_o && !stb_q) stb_rise++;
        if (wbm_ack_o) ack_cyc++;
        if (wbm_ack_o && !ack_q) ack_rise++;
        if (wbm_err_o) err_cyc++;
        if (wbm_err_o && !err_q) err_rise++;
        if (wbm_rty_o) rty_cyc++;
        if (wbm_rty_o && !rty_q) rty_rise++;
        stb_q = wbs_stb_o;
        ack_q = wbm_ack_o;
        err_q = wbm_err_o;
        rty_q = wbm_rty_o;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic master_req(input logic [31:0] adr, input logic [31:0] dat,
                              input logic we, input logic [3:0] sel);
        wbm_adr_i = adr;
        wbm_dat_i = dat;
        wbm_we_i  = we;
        wbm_sel_i = sel;
        wbm_cyc_i = 1'b1;
        wbm_stb_i = 1'b1;
    endtask

    task automatic master_idle();
        wbm_cyc_i = 1'b0;
        wbm_stb_i = 1'b0;
        wbm_we_i  = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        n_tests++;
        if ({wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b required 00000",
                     {wbs_cyc_o, wbs_stb_o, wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
        n_tests++;
        if ({wbs_adr_o, wbs_dat_o, wbm_dat_o, wbs_sel_o, wbs_we_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: adr=%h wdat=%h rdat=%h sel=%h we=%b required all 0",
                     wbs_adr_o, wbs_dat_o, wbm_dat_o, wbs_sel_o, wbs_we_o);
        end
        rst = 1'b0;
        step();
`ifdef WB_TIMEOUT_CNT_EN
        n_tests++;
        if (timeout_count_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_tcount: got %0d required 0", timeout_count_o);
        end
`endif
        $display("[TB] reset done");
    endtask

    task automatic test_read_ack();
        int s0, a0, ac0, e0, r0;
        s0 = stb_cyc; a0 = ack_rise; ac0 = ack_cyc; e0 = err_rise; r0 = rty_rise;
        master_req(32'h0000_0040, 32'h0, 1'b0, 4'hF);
        step();
        n_tests++;
        if (wbs_stb_o !== 1'b1 || wbs_cyc_o !== 1'b1 || wbs_adr_o !== 32'h0000_0040) begin
            n_fail++;
            $display("FAIL read_issue: stb=%b cyc=%b adr=%h required 1 1 00000040",
                     wbs_stb_o, wbs_cyc_o, wbs_adr_o);
        end
        step();
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'hDEAD_BEEF;
        step();
        wbs_ack_i = 1'b0;
        wbs_dat_i = 32'h0;
        n_tests++;
        if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL read_resp: ack=%b dat=%h required 1 deadbeef", wbm_ack_o, wbm_dat_o);
        end
        master_idle();
        step(); step();
        n_tests++;
        if (stb_cyc - s0 != 2 || ack_rise - a0 != 1 || ack_cyc - ac0 != 1) begin
            n_fail++;
            $display("FAIL read_counts: stb_cycles=%0d ack_pulses=%0d ack_cycles=%0d required 2 1 1",
                     stb_cyc - s0, ack_rise - a0, ack_cyc - ac0);
        end
        n_tests++;
        if (err_rise - e0 != 0 || rty_rise - r0 != 0 || wbm_dat_o !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL read_quiet: err=%0d rty=%0d dat=%h required 0 0 deadbeef",
                     err_rise - e0, rty_rise - r0, wbm_dat_o);
        end
        $display("[TB] read with ack: dat=%h", wbm_dat_o);
    endtask

    task automatic test_timeout();
        int s0, a0, e0, ec0, n;
        s0 = stb_cyc; a0 = ack_rise; e0 = err_rise; ec0 = err_cyc;
        master_req(32'h0000_1000, 32'h1234_5678, 1'b1, 4'hF);
        step();
        n_tests++;
        if (wbs_adr_o !== 32'h0000_1000 || wbs_dat_o !== 32'h1234_5678 ||
            wbs_we_o !== 1'b1 || wbs_sel_o !== 4'hF) begin
            n_fail++;
            $display("FAIL wr_issue: adr=%h dat=%h we=%b sel=%h required 00001000 12345678 1 f",
                     wbs_adr_o, wbs_dat_o, wbs_we_o, wbs_sel_o);
        end
        n = 0;
        while (!wbm_err_o && n < 20) begin
            step();
            n++;
        end
        n_tests++;
        if (n != 8 || wbs_cyc_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_timeout_latency: cycles_to_err=%0d cyc=%b required 8 0", n, wbs_cyc_o);
        end
        master_idle();
        step();
        wbs_ack_i = 1'b1;
        step(); step();
        wbs_ack_i = 1'b0;
        step();
        n_tests++;
        if (stb_cyc - s0 != 8) begin
            n_fail++;
            $display("FAIL wr_stb_cycles: got %0d required 8", stb_cyc - s0);
        end
        n_tests++;
        if (err_rise - e0 != 1 || err_cyc - ec0 != 1 || ack_rise - a0 != 0) begin
            n_fail++;
            $display("FAIL wr_timeout_resp: err_pulses=%0d err_cycles=%0d late_acks=%0d required 1 1 0",
                     err_rise - e0, err_cyc - ec0, ack_rise - a0);
        end
`ifdef WB_TIMEOUT_CNT_EN
        n_tests++;
        if (timeout_count_o !== 16'd1) begin
            n_fail++;
            $display("FAIL wr_tcount: got %0d required 1", timeout_count_o);
        end
`endif
        $display("[TB] write timeout: err after %0d cycles", n);
    endtask

    task automatic test_resp_priority();
        master_req(32'h0000_0080, 32'h0, 1'b0, 4'h3);
        step();
        wbs_ack_i = 1'b1; wbs_err_i = 1'b1; wbs_dat_i = 32'hCAFE_0001;
        step();
        wbs_ack_i = 1'b0; wbs_err_i = 1'b0;
        n_tests++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b100 || wbm_dat_o !== 32'hCAFE_0001) begin
            n_fail++;
            $display("FAIL prio_ack_err: ack/err/rty=%b dat=%h required 100 cafe0001",
                     {wbm_ack_o, wbm_err_o, wbm_rty_o}, wbm_dat_o);
        end
        master_idle();
        step(); step();
        master_req(32'h0000_0084, 32'h0, 1'b0, 4'hF);
        step();
        wbs_err_i = 1'b1;
        step();
        wbs_err_i = 1'b0;
        n_tests++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b010) begin
            n_fail++;
            $display("FAIL slave_err: ack/err/rty=%b required 010", {wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
        master_idle();
        step(); step();
`ifdef WB_TIMEOUT_CNT_EN
        n_tests++;
        if (timeout_count_o !== 16'd1) begin
            n_fail++;
            $display("FAIL slave_err_tcount: got %0d required 1", timeout_count_o);
        end
`endif
        master_req(32'h0000_0088, 32'h0, 1'b0, 4'hF);
        step();
        wbs_rty_i = 1'b1;
        step();
        wbs_rty_i = 1'b0;
        n_tests++;
        if ({wbm_ack_o, wbm_err_o, wbm_rty_o} !== 3'b001) begin
            n_fail++;
            $display("FAIL slave_rty: ack/err/rty=%b required 001", {wbm_ack_o, wbm_err_o, wbm_rty_o});
        end
        master_idle();
        step(); step();
        $display("[TB] response priority: ack+err, err, rty done");
    endtask

    task automatic test_back_to_back();
        int s0, a0, acks, n;
        s0 = stb_rise; a0 = ack_rise; acks = 0; n = 0;
        master_req(32'h0000_0100, 32'h0, 1'b0, 4'hF);
        while (acks < 3 && n < 40) begin
            step();
            n++;
            if (wbm_ack_o) begin
                n_tests++;
                if (wbm_dat_o !== 32'hB000_0000 + 32'(acks)) begin
                    n_fail++;
                    $display("FAIL b2b_data: beat %0d got %h required %h",
                             acks, wbm_dat_o, 32'hB000_0000 + 32'(acks));
                end
                acks++;
                if (acks == 3) master_idle();
            end
            wbs_ack_i = wbs_stb_o;
            wbs_dat_i = 32'hB000_0000 + 32'(acks);
        end
        wbs_ack_i = 1'b0;
        step(); step(); step();
        n_tests++;
        if (stb_rise - s0 != 3 || ack_rise - a0 != 3) begin
            n_fail++;
            $display("FAIL b2b_counts: stb_assertions=%0d ack_pulses=%0d required 3 3",
                     stb_rise - s0, ack_rise - a0);
        end
        $display("[TB] back-to-back: %0d acks in %0d cycles", acks, n);
    endtask

    task automatic test_abort_and_reset();
        int a0, e0, r0;
        a0 = ack_rise; e0 = err_rise; r0 = rty_rise;
        master_req(32'h0000_0200, 32'h0, 1'b0, 4'hF);
        step();
        step();
        master_idle();
        step();
        n_tests++;
        if (wbs_cyc_o !== 1'b0 || wbs_stb_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_release: cyc=%b stb=%b required 0 0", wbs_cyc_o, wbs_stb_o);
        end
        step(); step();
        n_tests++;
        if (ack_rise - a0 != 0 || err_rise - e0 != 0 || rty_rise - r0 != 0) begin
            n_fail++;
            $display("FAIL abort_quiet: ack=%0d err=%0d rty=%0d required 0 0 0",
                     ack_rise - a0, err_rise - e0, rty_rise - r0);
        end
        master_req(32'h0000_0300, 32'h5555_AAAA, 1'b1, 4'hC);
        step();
        n_tests++;
        if (wbs_stb_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre_busy: stb=%b required 1", wbs_stb_o);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({wbs_cyc_o, wbs_stb_o, wbs_we_o, wbm_ack_o, wbm_err_o, wbm_rty_o} !== 6'b0 ||
            wbs_adr_o !== '0 || wbs_dat_o !== '0 || wbm_dat_o !== '0 || wbs_sel_o !== '0) begin
            n_fail++;
            $display("FAIL rst_async_clear: flags=%b adr=%h wdat=%h rdat=%h sel=%h required all 0",
                     {wbs_cyc_o, wbs_stb_o, wbs_we_o, wbm_ack_o, wbm_err_o, wbm_rty_o},
                     wbs_adr_o, wbs_dat_o, wbm_dat_o, wbs_sel_o);
        end
        master_idle();
        step();
        rst = 1'b0;
        step();
        master_req(32'h0000_0400, 32'h0, 1'b0, 4'hF);
        step();
        wbs_ack_i = 1'b1;
        wbs_dat_i = 32'h0BAD_F00D;
        step();
        wbs_ack_i = 1'b0;
        n_tests++;
        if (wbm_ack_o !== 1'b1 || wbm_dat_o !== 32'h0BAD_F00D) begin
            n_fail++;
            $display("FAIL post_rst_read: ack=%b dat=%h required 1 0badf00d", wbm_ack_o, wbm_dat_o);
        end
        master_idle();
        step(); step();
        $display("[TB] abort and mid-access reset done");
    endtask

    initial begin
        test_reset();
        test_read_ack();
        test_timeout();
        test_resp_priority();
        test_back_to_back();
        test_abort_and_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/wb_timeout_reg.md
Name: wb_timeout_reg

Overview:
- Registered single-outstanding Wishbone pipeline stage with a bus watchdog.
- Placed directly downstream of the 2-port Wishbone arbiter's slave port: the arbiter's wbs_* outputs feed this block's wbm_* inputs.
- Breaks the combinational path to the slave.
- Terminates any access the slave fails to answer within TIMEOUT cycles with an error, so a hung slave cannot lock the arbiter.

Parameters:
DATA_WIDTH, 32, data bus width in bits (8, 16, 32, 64)
ADDR_WIDTH, 32, address bus width in bits
SELECT_WIDTH, DATA_WIDTH/8, byte select width
TIMEOUT, 256, slave cycles allowed before error; 0 disables the watchdog
CNT_WIDTH, 9, watchdog counter width; must hold TIMEOUT

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
wbm_adr_i  in  ADDR_WIDTH  master address
wbm_dat_i  in  DATA_WIDTH  master write data
wbm_dat_o  out  DATA_WIDTH  read data to master
wbm_we_i  in  1  write enable
wbm_sel_i  in  SELECT_WIDTH  byte select
wbm_stb_i  in  1  strobe
wbm_ack_o  out  1  acknowledge
wbm_err_o  out  1  error (slave error or timeout)
wbm_rty_o  out  1  retry
wbm_cyc_i  in  1  cycle
wbs_adr_o  out  ADDR_WIDTH  slave address
wbs_dat_i  in  DATA_WIDTH  slave read data
wbs_dat_o  out  DATA_WIDTH  slave write data
wbs_we_o  out  1  write enable
wbs_sel_o  out  SELECT_WIDTH  byte select
wbs_stb_o  out  1  strobe
wbs_ack_i  in  1  acknowledge
wbs_err_i  in  1  error
wbs_rty_i  in  1  retry
wbs_cyc_o  out  1  cycle

Behaviour:
- Reset:
  - Asynchronous, rst high; all outputs registered.
  - State returns to IDLE.
  - All wbm_* and wbs_* outputs, the data registers and the counter clear to 0.
  - A reset mid-access drops wbs_cyc_o/wbs_stb_o immediately; no response is issued.
- States:
  - IDLE: no access in flight.
  - BUSY: wbs_cyc_o = wbs_stb_o = 1.
  - RESP: one-cycle response to the master.
- IDLE:
  - If wbm_cyc_i & wbm_stb_i are sampled high, register adr/dat/we/sel into the wbs_* outputs, set wbs_cyc_o/wbs_stb_o, clear the counter, and go to BUSY.
  - The slave therefore sees the request 1 cycle after the master presents it.
- BUSY, resolved in this priority order:
  - wbm_cyc_i low (master abort): clear wbs_cyc_o/wbs_stb_o, go to IDLE, no response.
  - Any of wbs_ack_i/wbs_err_i/wbs_rty_i high:
    - Capture wbs_dat_i into wbm_dat_o and clear wbs_cyc_o/wbs_stb_o.
    - Forward exactly one flag, priority ack > err > rty. Only on reads (we=0) does the captured data carry meaning.
    - Go to RESP.
  - Else, if TIMEOUT != 0 and counter == TIMEOUT-1: clear wbs_cyc_o/wbs_stb_o, set wbm_err_o, go to RESP. The slave therefore gets exactly TIMEOUT cycles of strobe.
  - Else increment the counter.
  - A slave response in the timeout cycle wins over the timeout.
- RESP:
  - The response flag is high for exactly this one cycle; go to IDLE next.
  - wbm_stb_i is ignored in RESP, so a held strobe cannot double-issue. The next request is sampled in IDLE.
  - wbm_dat_o holds its value until the next response.
- Latency:
  - Request sampled at edge k → wbs_stb_o high from k+1.
  - Slave response sampled at edge m → wbm_ack_o high during cycle m+1.
  - Minimum round trip is 3 cycles from master strobe to master ack.
- Slave responses outside BUSY are ignored, including late acks after a timeout.
- Counter:
  - Unsigned, CNT_WIDTH bits, no wrap: it is only compared against TIMEOUT-1.
  - If TIMEOUT = 0 it never triggers.

Optional Feature:
- Macro: WB_TIMEOUT_CNT_EN.
- Defined:
  - Adds output port timeout_count_o, 16 bits.
  - Saturating count of watchdog-generated errors; saturates at 16'hFFFF.
  - Increments in the cycle the block enters RESP due to timeout.
  - Reset to 0 by rst.
  - Slave-issued errors do not count.
- Not defined: port absent, no counter logic; behaviour otherwise identical.

Test Plan:
- Read, slave acks 2 cycles after wbs_stb_o, wbs_dat_i=32'hDEADBEEF → wbm_ack_o one-cycle pulse, wbm_dat_o=32'hDEADBEEF, wbs_stb_o high exactly 2 cycles, wbm_err_o/wbm_rty_o stay 0.
- Write adr=32'h00001000, dat=32'h12345678, sel=4'hF, slave never responds, TIMEOUT=8 → wbs_stb_o high exactly 8 cycles, then wbm_err_o one-cycle pulse; slave ack 2 cycles later ignored (no wbm_ack_o); timeout_count_o=1 with WB_TIMEOUT_CNT_EN.
- Slave asserts wbs_ack_i and wbs_err_i together → only wbm_ack_o pulses. Separately, wbs_err_i alone → wbm_err_o pulses, and timeout_count_o stays unchanged.
- Master holds wbm_stb_i high across 3 back-to-back reads, slave acks 1 cycle after each strobe → exactly 3 wbs_stb_o assertions and 3 wbm_ack_o pulses, never two accesses per request.
- Master drops wbm_cyc_i in the 2nd BUSY cycle → wbs_cyc_o low next cycle, no wbm_ack_o/err/rty. Separately, rst asserted mid-BUSY → all outputs 0 immediately, and a following read completes normally.
